flit_inject: RTL and testbench

Local injection unit for the MinBD two-lane deflection datapath. Buffers flits produced by the local node and inserts them into empty slots of the lane pair feeding the two-input deflection arbiter. It is the transmit-side counterpart of that arbiter, supplying lanes that the arbiter later permutes. A starvation counter flags a node that cannot inject and can optionally promote the waiting flit to golden.

---
 rtl/minbd_pkg.sv | 26 ++
 rtl/inj_fifo.sv | 49 ++++
 rtl/flit_inject.sv | 120 ++++++++++++
 tb/tb_flit_inject.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/minbd_pkg.sv
// Shared flit format for the MinBD two-lane deflection datapath.
// Used by the deflection arbiter and by the local injection unit.
package minbd_pkg;

    localparam int FLIT_W   = 11;
    localparam int BODY_W   = 9;
    localparam int GOLD_BIT = 10;
    localparam int VLD_BIT  = 9;
    localparam int DIR_MSB  = 8;
    localparam int DIR_LSB  = 6;
    localparam int PAY_W    = 6;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_WEST  = 3'd4
    } dir_e;

    // A slot may be claimed only when it carries neither a valid nor a golden flit.
    function automatic logic slot_empty(input logic [FLIT_W-1:0] f);
        return ~(f[GOLD_BIT] | f[VLD_BIT]);
    endfunction

endpackage

// File: rtl/inj_fifo.sv
// Local flit buffer for the injection unit: DEPTH x W synchronous FIFO.
// Pointers carry an extra MSB so full and empty are distinguishable.
module inj_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_wr;
    logic         w_rd;

    assign o_count = r_wp - r_rp;
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_wr    = i_push & ~o_full;
    assign w_rd    = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rp[AW-1:0]];

    // Read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= {(AW+1){1'b0}};
            r_rp <= {(AW+1){1'b0}};
        end else begin
            if (w_wr) r_wp <= r_wp + {{AW{1'b0}}, 1'b1};
            if (w_rd) r_rp <= r_rp + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array; stale contents are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/flit_inject.sv
// Local injection unit: places buffered local flits into empty lane slots.
// Optional feature macro: INJ_GOLDEN_EN (starved flit is injected as golden).
module flit_inject
    import minbd_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [BODY_W-1:0]        in_flit,
    input  logic [FLIT_W-1:0]        lane1_i,
    input  logic [FLIT_W-1:0]        lane2_i,
    output logic [FLIT_W-1:0]        lane1_o,
    output logic [FLIT_W-1:0]        lane2_o,
    output logic                     starve_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [BODY_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_inj1;
    logic              w_inj2;
    logic              w_gold;
    logic [FLIT_W-1:0] w_inj_word;
    logic [FLIT_W-1:0] w_lane1_nxt;
    logic [FLIT_W-1:0] w_lane2_nxt;
    logic [SW-1:0]     w_scnt_nxt;
    logic [FLIT_W-1:0] r_lane1;
    logic [FLIT_W-1:0] r_lane2;
    logic [SW-1:0]     r_scnt;
    logic              r_starve;
    logic              r_live;

    // in_rdy is held low until the first edge after reset release.
    assign in_rdy   = r_live & ~w_full;
    assign w_push   = in_vld & in_rdy;
    assign lane1_o  = r_lane1;
    assign lane2_o  = r_lane2;
    assign starve_o = r_starve;

    inj_fifo #(
        .DEPTH (DEPTH),
        .W     (BODY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (in_flit),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count_o)
    );

    // Slot selection: lane1 has priority, at most one injection per cycle.
    always_comb begin
        w_inj1 = 1'b0;
        w_inj2 = 1'b0;
        if (!w_empty) begin
            if (slot_empty(lane1_i)) begin
                w_inj1 = 1'b1;
            end else if (slot_empty(lane2_i)) begin
                w_inj2 = 1'b1;
            end else begin
                w_inj1 = 1'b0;
            end
        end else begin
            w_inj2 = 1'b0;
        end
        w_pop = w_inj1 | w_inj2;
`ifdef INJ_GOLDEN_EN
        w_gold = r_starve;
`else
        w_gold = 1'b0;
`endif
        w_inj_word  = {w_gold, 1'b1, w_head};
        w_lane1_nxt = w_inj1 ? w_inj_word : lane1_i;
        w_lane2_nxt = w_inj2 ? w_inj_word : lane2_i;
    end

    // Starvation counter: counts blocked cycles while a flit waits.
    always_comb begin
        w_scnt_nxt = r_scnt;
        if (w_pop || w_empty) begin
            w_scnt_nxt = {SW{1'b0}};
        end else if (r_scnt == STARVE_MAX) begin
            w_scnt_nxt = STARVE_MAX;
        end else begin
            w_scnt_nxt = r_scnt + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    // Lane output registers, starvation state and ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane1  <= {FLIT_W{1'b0}};
            r_lane2  <= {FLIT_W{1'b0}};
            r_scnt   <= {SW{1'b0}};
            r_starve <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_lane1  <= w_lane1_nxt;
            r_lane2  <= w_lane2_nxt;
            r_scnt   <= w_scnt_nxt;
            r_starve <= (w_scnt_nxt == STARVE_MAX);
            r_live   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flit_inject.sv
// Directed bench for flit_inject (DEPTH=4, STARVE_LIMIT=8).
// Golden-bit expectation follows INJ_GOLDEN_EN when defined.
module tb_flit_inject;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [8:0]  in_flit;
    logic [10:0] lane1_i;
    logic [10:0] lane2_i;
    logic [10:0] lane1_o;
    logic [10:0] lane2_o;
    logic        starve_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    flit_inject #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_flit  (in_flit),
        .lane1_i  (lane1_i),
        .lane2_i  (lane2_i),
        .lane1_o  (lane1_o),
        .lane2_o  (lane2_o),
        .starve_o (starve_o),
        .count_o  (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [10:0] gold_word;
`ifdef INJ_GOLDEN_EN
        gold_word = 11'h6C3;
`else
        gold_word = 11'h2C3;
`endif
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_flit = 9'h000;
        lane1_i = 11'h000;
        lane2_i = 11'h000;
        tick();
        tick();
        chk("rst_rdy", in_rdy, 0);
        chk("rst_l1", lane1_o, 0);
        chk("rst_l2", lane2_o, 0);
        chk("rst_cnt", count_o, 0);
        chk("rst_starve", starve_o, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_rdy", in_rdy, 1);

        // single push, injected into lane1 one cycle after it becomes head
        in_vld = 1'b1; in_flit = 9'h1A5;
        tick();
        chk("push_cnt", count_o, 1);
        chk("nobypass_l1", lane1_o, 11'h000);
        in_vld = 1'b0;
        tick();
        chk("inj_l1", lane1_o, 11'h3A5);
        chk("inj_cnt", count_o, 0);
        tick();
        chk("idle_l1", lane1_o, 11'h000);

        // lane1 busy: injection into lane2
        lane1_i = 11'h200;
        in_vld = 1'b1; in_flit = 9'h055;
        tick();
        in_vld = 1'b0;
        tick();
        chk("l2_inj", lane2_o, 11'h255);
        chk("l2_pass1", lane1_o, 11'h200);
        chk("l2_cnt", count_o, 0);

        // both lanes busy: starvation
        lane2_i = 11'h2AA;
        in_vld = 1'b1; in_flit = 9'h0C3;
        tick();
        in_vld = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("starve_pre", starve_o, 0);
        tick();
        chk("starve_rise", starve_o, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("starve_hold", starve_o, 1);
        chk("blk_l1", lane1_o, 11'h200);
        chk("blk_l2", lane2_o, 11'h2AA);
        chk("blk_cnt", count_o, 1);
        lane2_i = 11'h000;
        tick();
        chk("starve_inj", lane2_o, gold_word);
        chk("starve_clr", starve_o, 0);
        chk("starve_cnt", count_o, 0);

        // fill FIFO with both lanes busy
        lane2_i = 11'h2AA;
        in_vld = 1'b1;
        in_flit = 9'h101; tick();
        in_flit = 9'h102; tick();
        in_flit = 9'h103; tick();
        in_flit = 9'h104; tick();
        chk("full_cnt", count_o, 4);
        chk("full_rdy", in_rdy, 0);
        in_flit = 9'h105;
        tick();
        chk("full_hold", count_o, 4);
        lane1_i = 11'h000;
        tick();
        chk("full_pop_l1", lane1_o, 11'h301);
        chk("full_nopush", count_o, 3);
        chk("full_rdy2", in_rdy, 1);
        lane1_i = 11'h200;
        tick();
        chk("late_push", count_o, 4);
        in_vld = 1'b0;

        // golden-but-invalid lane1 is never overwritten
        lane1_i = 11'h400;
        lane2_i = 11'h000;
        tick();
        chk("gold_l1", lane1_o, 11'h400);
        chk("gold_l2", lane2_o, 11'h302);
        chk("gold_cnt", count_o, 3);

        // mid-stream reset
        lane1_i = 11'h200;
        lane2_i = 11'h2AA;
        rst_n = 1'b0;
        #1;
        chk("mrst_l1", lane1_o, 0);
        chk("mrst_l2", lane2_o, 0);
        chk("mrst_cnt", count_o, 0);
        chk("mrst_rdy", in_rdy, 0);
        chk("mrst_starve", starve_o, 0);
        lane1_i = 11'h000;
        lane2_i = 11'h000;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_l1", lane1_o, 0);
        chk("post_l2", lane2_o, 0);
        chk("post_cnt", count_o, 0);

        // simultaneous push and pop keeps count and order
        in_vld = 1'b1; in_flit = 9'h0AA;
        tick();
        chk("pp_cnt1", count_o, 1);
        in_flit = 9'h155;
        tick();
        chk("pp_l1a", lane1_o, 11'h2AA);
        chk("pp_cnt2", count_o, 1);
        in_vld = 1'b0;
        tick();
        chk("pp_l1b", lane1_o, 11'h355);
        chk("pp_cnt3", count_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
